// File: rtl/polyveck_cfreeze_stream.sv
// ============================================================================
// polyveck_cfreeze_stream: streams a K-poly vector and centers each coefficient
// from [0,Q) to [-(Q-1)/2,(Q-1)/2], tagging indices and end-of-vector.
// Optional: define CFREEZE_RANGE_CHECK_EN for a sticky range_err output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module polyveck_cfreeze_stream #(
  parameter int K = 6,
  parameter int N = 256,
  parameter int Q = 8380417,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [2:0]   m_poly_idx,
  output logic [7:0]   m_coef_idx,
  output logic         m_last,
  output logic         done
`ifdef CFREEZE_RANGE_CHECK_EN
  ,
  output logic         range_err
`endif
);

  localparam logic signed [W-1:0] C_HALF      = W'((Q - 1) / 2);
  localparam logic        [W-1:0] C_Q         = W'(Q);
  localparam logic        [2:0]   C_POLY_MAX  = 3'(K - 1);
  localparam logic        [7:0]   C_COEF_MAX  = 8'(N - 1);

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   poly;
    logic [7:0]   coef;
    logic         last;
  } beat_t;

  beat_t       head_q, head_d, tail_q, tail_d, new_beat;
  logic [1:0]  count_q, count_d;
  logic        s_ready_q, s_ready_d;
  logic        done_q, done_d;
  logic [2:0]  poly_q, poly_d;
  logic [7:0]  coef_q, coef_d;
  logic        push, pop;

  always_comb begin
    push = s_valid & s_ready_q;
    pop  = (count_q != 2'd0) & m_ready;

    new_beat.data = ($signed(s_data) > C_HALF) ? (s_data - C_Q) : s_data;
    new_beat.poly = poly_q;
    new_beat.coef = coef_q;
    new_beat.last = (poly_q == C_POLY_MAX) && (coef_q == C_COEF_MAX);

    poly_d = poly_q;
    coef_d = coef_q;
    if (push) begin
      if (coef_q == C_COEF_MAX) begin
        coef_d = 8'd0;
        poly_d = (poly_q == C_POLY_MAX) ? 3'd0 : poly_q + 3'd1;
      end else begin
        coef_d = coef_q + 8'd1;
      end
    end

    // head is the registered output stage; tail is the skid slot
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = new_beat;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_beat;
        end else if (pop) begin
          count_d = 2'd0;
        end else if (push) begin
          tail_d  = new_beat;
          count_d = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase

    s_ready_d = (count_d != 2'd2);
    done_d    = pop & head_q.last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
      s_ready_q <= 1'b1;
      done_q    <= 1'b0;
      poly_q    <= 3'd0;
      coef_q    <= 8'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      done_q    <= done_d;
      poly_q    <= poly_d;
      coef_q    <= coef_d;
    end
  end

`ifdef CFREEZE_RANGE_CHECK_EN
  logic range_err_q, range_err_d;

  always_comb begin
    range_err_d = range_err_q;
    if (push && (s_data[W-1] || (s_data >= C_Q))) begin
      range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign range_err = range_err_q;
`endif

  assign s_ready    = s_ready_q;
  assign m_valid    = (count_q != 2'd0);
  assign m_data     = head_q.data;
  assign m_poly_idx = head_q.poly;
  assign m_coef_idx = head_q.coef;
  assign m_last     = head_q.last & m_valid;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_polyveck_cfreeze_stream.sv
// ============================================================================
// tb_polyveck_cfreeze_stream: randomized self-checking bench with a queue-based
// reference model of the centering stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_polyveck_cfreeze_stream;

  localparam int K    = 6;
  localparam int N    = 256;
  localparam int Q    = 8380417;
  localparam int W    = 32;
  localparam int VLEN = K * N;
  localparam int HALF = (Q - 1) / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_ready, m_valid, m_last, done;
  logic [31:0] m_data;
  logic [2:0]  m_poly_idx;
  logic [7:0]  m_coef_idx;
`ifdef CFREEZE_RANGE_CHECK_EN
  logic        range_err;
`endif

  polyveck_cfreeze_stream #(.K(K), .N(N), .Q(Q), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_poly_idx (m_poly_idx),
    .m_coef_idx (m_coef_idx),
    .m_last     (m_last),
    .done       (done)
`ifdef CFREEZE_RANGE_CHECK_EN
    ,
    .range_err  (range_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          poly;
    int          coef;
    bit          last;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          beat_no = 0;
  bit          next_done = 0;
  bit          done_expect = 0;
  logic        obs_valid, obs_last, obs_done, obs_sready;
  logic [31:0] obs_data;
  logic [2:0]  obs_poly;
  logic [7:0]  obs_coef;
  bit          acc, pop;

  function automatic logic [31:0] centered(input logic [31:0] x);
    int sx;
    sx = $signed(x);
    if (sx > HALF) return 32'(sx - Q);
    return x;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input int n);
    exp_t e;
    int   i;
    i = n % VLEN;
    e.data = centered(d);
    e.poly = i / N;
    e.coef = i % N;
    e.last = (i == VLEN - 1);
    return e;
  endfunction

  function automatic logic [31:0] rnd_coef();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'($urandom_range(0, Q - 1));
  endfunction

  // One cycle: drive at negedge, sample settled outputs, log acceptance.
  task automatic tick(input bit v, input logic [31:0] d, input bit r);
    s_valid = v; s_data = d; m_ready = r;
    #1;
    obs_valid = m_valid; obs_data = m_data; obs_poly = m_poly_idx;
    obs_coef = m_coef_idx; obs_last = m_last; obs_done = done; obs_sready = s_ready;
    acc = v && obs_sready;
    pop = obs_valid && r;
    done_expect = next_done;
    next_done = 0;
    if (acc) begin
      q.push_back(mk(d, beat_no));
      beat_no++;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 32'd0;
    q.delete(); beat_no = 0; next_done = 0; done_expect = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    n_cmp++; if (m_data !== 32'd0) begin n_fail++; $display("FAIL reset_m_data got=%h want=0", m_data); end
    n_cmp++; if ({m_poly_idx, m_coef_idx} !== 11'd0) begin n_fail++; $display("FAIL reset_idx got=(%0d,%0d) want=(0,0)", m_poly_idx, m_coef_idx); end
    n_cmp++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got=%b want=0", m_last); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_beats();
    logic [31:0] vin [4];
    logic [31:0] want [4];
    exp_t e;
    vin  = '{32'd0, 32'd4190208, 32'd4190209, 32'd8380416};
    want = '{32'd0, 32'd4190208, 32'hFFC01000, 32'hFFFFFFFF};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, vin[i], 1'b1);
      n_cmp++; if (!acc) begin n_fail++; $display("FAIL single_accept[%0d] s_ready=%b want=1", i, obs_sready); end
      tick(1'b0, 32'd0, 1'b1);
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_data !== want[i] || obs_poly !== 3'd0 || obs_coef !== 8'(i)) begin
        n_fail++;
        $display("FAIL single_beat[%0d] got valid=%b data=%h idx=(%0d,%0d) want valid=1 data=%h idx=(0,%0d)",
                 i, obs_valid, obs_data, obs_poly, obs_coef, want[i], i);
      end
      if (q.size() > 0) e = q.pop_front();
    end
  endtask

  task automatic test_full_vector();
    exp_t e;
    int fed = 0, outs = 0, lasts = 0, first_cyc = -1, last_cyc = -1;
    apply_reset();
    for (int cyc = 0; cyc < 2000 && outs < VLEN; cyc++) begin
      tick(fed < VLEN, rnd_coef(), 1'b1);
      if (acc) fed++;
      if (pop) begin
        n_cmp++;
        if (q.size() == 0) begin n_fail++; $display("FAIL full_extra_beat got data=%h want none", obs_data); end
        else begin
          e = q.pop_front();
          if ({obs_data, obs_poly, obs_coef, obs_last} !== {e.data, 3'(e.poly), 8'(e.coef), e.last}) begin
            n_fail++;
            $display("FAIL full_beat got %h (%0d,%0d) last=%b want %h (%0d,%0d) last=%b",
                     obs_data, obs_poly, obs_coef, obs_last, e.data, e.poly, e.coef, e.last);
          end
          next_done = e.last;
        end
        outs++;
        if (obs_last) lasts++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      n_cmp++; if (obs_done !== done_expect) begin n_fail++; $display("FAIL full_done got=%b want=%b", obs_done, done_expect); end
    end
    tick(1'b0, 32'd0, 1'b1);
    n_cmp++; if (obs_done !== 1'b1) begin n_fail++; $display("FAIL full_done_pulse got=%b want=1", obs_done); end
    n_cmp++; if (outs != VLEN) begin n_fail++; $display("FAIL full_count got=%0d want=%0d", outs, VLEN); end
    n_cmp++; if (last_cyc - first_cyc != VLEN - 1) begin n_fail++; $display("FAIL full_b2b span got=%0d want=%0d", last_cyc - first_cyc, VLEN - 1); end
    n_cmp++; if (lasts != 1) begin n_fail++; $display("FAIL full_last_count got=%0d want=1", lasts); end
    tick(1'b0, 32'd0, 1'b1);
    n_cmp++; if (obs_done !== 1'b0) begin n_fail++; $display("FAIL full_done_width got=%b want=0", obs_done); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [42:0] held;
    int stall_acc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bit stall;
      stall = (cyc >= 10 && cyc < 15);
      if (cyc < 25) tick(1'b1, rnd_coef(), !stall);
      else          tick(1'b0, 32'd0, 1'b1);
      if (stall && acc) stall_acc++;
      if (cyc == 10) held = {obs_data, obs_poly, obs_coef};
      if (cyc >= 11 && cyc < 15) begin
        n_cmp++; if (obs_sready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready[%0d] got=%b want=0", cyc, obs_sready); end
        n_cmp++; if ({obs_data, obs_poly, obs_coef} !== held) begin n_fail++; $display("FAIL bp_hold[%0d] got=%h want=%h", cyc, {obs_data, obs_poly, obs_coef}, held); end
      end
      if (pop) begin
        n_cmp++;
        if (q.size() == 0) begin n_fail++; $display("FAIL bp_extra_beat got data=%h want none", obs_data); end
        else begin
          e = q.pop_front();
          if ({obs_data, obs_poly, obs_coef, obs_last} !== {e.data, 3'(e.poly), 8'(e.coef), e.last}) begin
            n_fail++;
            $display("FAIL bp_beat got %h (%0d,%0d) want %h (%0d,%0d)", obs_data, obs_poly, obs_coef, e.data, e.poly, e.coef);
          end
          next_done = e.last;
        end
      end
      n_cmp++; if (obs_done !== done_expect) begin n_fail++; $display("FAIL bp_done got=%b want=%b", obs_done, done_expect); end
    end
    n_cmp++; if (stall_acc != 1) begin n_fail++; $display("FAIL bp_stall_accepts got=%0d want=1", stall_acc); end
    n_cmp++; if (q.size() != 0) begin n_fail++; $display("FAIL bp_lost_beats got=%0d pending want=0", q.size()); end
  endtask

  task automatic test_random_vectors();
    exp_t e;
    int target = 3 * VLEN;
    int fed = 0, lasts = 0;
    apply_reset();
    for (int cyc = 0; cyc < 40000 && (fed < target || q.size() > 0); cyc++) begin
      tick((fed < target) && ($urandom_range(0, 3) != 0), rnd_coef(), $urandom_range(0, 2) != 0);
      if (acc) fed++;
      if (pop) begin
        n_cmp++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rand_extra_beat got data=%h want none", obs_data); end
        else begin
          e = q.pop_front();
          if ({obs_data, obs_poly, obs_coef, obs_last} !== {e.data, 3'(e.poly), 8'(e.coef), e.last}) begin
            n_fail++;
            $display("FAIL rand_beat got %h (%0d,%0d) last=%b want %h (%0d,%0d) last=%b",
                     obs_data, obs_poly, obs_coef, obs_last, e.data, e.poly, e.coef, e.last);
          end
          next_done = e.last;
        end
        if (obs_last) lasts++;
      end
      n_cmp++; if (obs_done !== done_expect) begin n_fail++; $display("FAIL rand_done got=%b want=%b", obs_done, done_expect); end
    end
    n_cmp++; if (fed != target || q.size() != 0) begin n_fail++; $display("FAIL rand_timeout fed=%0d pending=%0d want fed=%0d pending=0", fed, q.size(), target); end
    n_cmp++; if (lasts != 3) begin n_fail++; $display("FAIL rand_last_count got=%0d want=3", lasts); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    for (int cyc = 0; cyc < 1000 && beat_no < 2 * N + 101; cyc++) tick(1'b1, rnd_coef(), 1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid got=%b want=0", m_valid); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_s_ready got=%b want=1", s_ready); end
    q.delete(); beat_no = 0; next_done = 0; s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick(1'b1, 32'd5000000, 1'b1);
    tick(1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (!pop || q.size() == 0) begin n_fail++; $display("FAIL rstmid_first_beat got valid=%b want=1", obs_valid); end
    else begin
      e = q.pop_front();
      if ({obs_data, obs_poly, obs_coef} !== {e.data, 3'(e.poly), 8'(e.coef)} || obs_poly !== 3'd0 || obs_coef !== 8'd0) begin
        n_fail++;
        $display("FAIL rstmid_first_beat got %h (%0d,%0d) want %h (0,0)", obs_data, obs_poly, obs_coef, e.data);
      end
    end
  endtask

`ifdef CFREEZE_RANGE_CHECK_EN
  task automatic test_range_err();
    exp_t e;
    apply_reset();
    n_cmp++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL rerr_reset got=%b want=0", range_err); end
    tick(1'b1, 32'hFFFFFFFF, 1'b1);
    tick(1'b0, 32'd0, 1'b1);
    n_cmp++; if (obs_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rerr_data_neg got=%h want=ffffffff", obs_data); end
    n_cmp++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL rerr_set got=%b want=1", range_err); end
    if (q.size() > 0) e = q.pop_front();
    tick(1'b1, 32'(Q), 1'b1);
    tick(1'b0, 32'd0, 1'b1);
    n_cmp++; if (obs_data !== 32'h00000000) begin n_fail++; $display("FAIL rerr_data_q got=%h want=00000000", obs_data); end
    if (q.size() > 0) e = q.pop_front();
    tick(1'b1, 32'd7, 1'b1);
    repeat (3) tick(1'b0, 32'd0, 1'b1);
    n_cmp++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL rerr_sticky got=%b want=1", range_err); end
    apply_reset();
    n_cmp++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL rerr_clear got=%b want=0", range_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_beats();
    test_full_vector();
    test_backpressure();
    test_random_vectors();
    test_reset_mid();
`ifdef CFREEZE_RANGE_CHECK_EN
    test_range_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/polyveck_cfreeze_stream.md
Name: polyveck_cfreeze_stream

Overview:
- Streaming inverse of the vector conditional-add-q stage. Maps each coefficient from the canonical range [0, q) to the centered range [-(q-1)/2, (q-1)/2]: subtract q when a > (q-1)/2.
- Consumes a K-polynomial vector one 32-bit coefficient per beat over a valid/ready handshake, emits one beat per input, and tags polynomial/coefficient indices and end-of-vector.
- Sits between the serial coefficient memory readers and the packing/Power2Round consumers that need centered representatives.

Parameters:
- K, 6, number of polynomials per vector.
- N, 256, coefficients per polynomial (power of two).
- Q, 8380417, modulus.
- W, 32, coefficient width in bits, signed two's complement.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input coefficient valid.
- s_ready  output  1  block can accept a coefficient this cycle.
- s_data  input  W  input coefficient, nominally in [0, Q).
- m_valid  output  1  output coefficient valid.
- m_ready  input  1  downstream accepts this cycle.
- m_data  output  W  centered coefficient, signed.
- m_poly_idx  output  3  polynomial index 0..K-1 of m_data.
- m_coef_idx  output  8  coefficient index 0..N-1 of m_data.
- m_last  output  1  high on the final beat of the vector (poly K-1, coef N-1).
- done  output  1  one-cycle pulse after the m_last beat is accepted.

Behaviour:
- Reset (async assert, sync-release usage): m_valid=0, m_data=0, m_poly_idx=0, m_coef_idx=0, m_last=0, done=0, s_ready=1. Input counters cleared, buffer emptied.
- Arithmetic: HALF=(Q-1)/2=4190208. If s_data > HALF (signed compare), out = s_data - Q, else out = s_data. Computed in W bits with no saturation. An input is accepted on s_valid & s_ready.
- Pipeline: registered output, 2-entry skid buffer. Latency is 1 cycle from acceptance to m_valid when not stalled. s_ready = buffer not full, so it is registered with no combinational path from m_ready. Full throughput of 1 beat/cycle is sustained while m_ready=1.
- Transfer: a beat completes on m_valid & m_ready. m_data, m_poly_idx, m_coef_idx and m_last hold stable while m_valid & !m_ready.
- Counters: coef_cnt advances on each accepted input and wraps N-1 -> 0, incrementing poly_cnt. poly_cnt wraps K-1 -> 0. Indices travel with the data through the buffer.
- m_last=1 exactly when the tagged indices are (K-1, N-1). The next accepted input starts a new vector at (0, 0) with no idle cycle required.
- done pulses 1 cycle, in the cycle after the m_last beat transfers.
- Simultaneous push and pop with a full buffer: pop frees a slot, but s_ready stays registered, so the push is refused that cycle.
- Reset mid-vector discards all buffered beats and indices. The next vector starts at (0, 0).
- Inputs outside [0, Q) still go through the same formula. No other checking is done unless the optional feature is enabled.

Optional Feature:
- Macro CFREEZE_RANGE_CHECK_EN.
- Defined: adds output port range_err (1 bit, reset 0). It is a sticky flag, set when an accepted s_data is < 0 or >= Q, and cleared only by rst_n. Data is still processed normally.
- Undefined: no port and no compare logic.

Test Plan:
- Single beats 0, 4190208, 4190209, 8380416 -> m_data 0, 4190208, -4190208 (0xFFC01000), -1 (0xFFFFFFFF). Each appears 1 cycle after acceptance.
- Full vector of 1536 beats, s_valid=1, m_ready=1 -> 1536 outputs back-to-back. m_last only on beat 1535 with idx (5, 255). done pulses the next cycle. Indices wrap 255 -> 0 with poly increment.
- Backpressure: m_ready=0 for 5 cycles mid-stream -> s_ready drops after 2 buffered beats. m_data and indices stay stable. No loss or duplication after release; output order matches input order.
- Random s_valid/m_ready toggling over 3 consecutive vectors -> output matches the reference model, with m_last every 1536th beat.
- Assert rst_n=0 at coefficient (2, 100) -> m_valid=0 immediately. After release, the first accepted beat is tagged (0, 0).
- With CFREEZE_RANGE_CHECK_EN defined, input -1 then 8380417 -> range_err rises after the first acceptance and stays 1 until reset. Outputs are 0xFFFFFFFF and 0x00000000.
